button_conditioner: RTL and testbench

- Input-conditioning stage that sits directly upstream of the clock/counter chain and display core.
- Takes two raw, asynchronous, bouncing push-buttons and produces clean control signals: a RUN level for the seconds prescaler CE, and a CLR level and pulse for the counter chain RST.
- Each button goes through a 2-flop synchroniser and a 4-state debounce FSM with a dwell counter.
- Each press yields exactly one single-cycle event, regardless of how long the button is held or how much it bounces.

---
 rtl/button_conditioner.sv | 135 +++++++++++++
 tb/tb_button_conditioner.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: two-button input conditioner for the clock/counter chain.
// Each raw button is synchronised (2 flops), then debounced by a 4-state FSM
// with a dwell counter. Button A toggles the RUN level once per accepted press.
// Button B drives the CLR level and a single-cycle CLR pulse. B forces RUN low.
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned CNT_BITS  = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic A,
    input  logic B,
    output logic RUN,
    output logic PRESS_A,
    output logic CLR,
    output logic CLR_PULSE
);

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        PRESSED,
        CHK_REL
    } db_state_e;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DB_CYCLES - 1);

    // Index 0 is button A, index 1 is button B.
    logic [1:0]          s1_q;
    logic [1:0]          s2_q;
    db_state_e           state_q [2];
    db_state_e           state_d [2];
    logic [CNT_BITS-1:0] cnt_q   [2];
    logic [CNT_BITS-1:0] cnt_d   [2];
    logic [1:0]          press_q;
    logic [1:0]          press_d;
    logic                run_q;
    logic                run_d;
    logic                clr_q;
    logic                clr_d;

    // Synchronisers, FSM state, dwell counters and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q    <= '0;
            s2_q    <= '0;
            press_q <= '0;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= {B, A};
            s2_q    <= s1_q;
            press_q <= press_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Debounce next-state and dwell counter for each button.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (s2_q[i]) begin
                        state_d[i] = CHK_PRESS;
                        cnt_d[i]   = '0;
                    end
                end
                CHK_PRESS: begin
                    if (!s2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2_q[i]) begin
                        state_d[i] = CHK_REL;
                        cnt_d[i]   = '0;
                    end
                end
                CHK_REL: begin
                    if (s2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Press events, CLR level and RUN update; B press overrides an A toggle.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            press_d[i] = (state_q[i] == CHK_PRESS) && s2_q[i] && (cnt_q[i] == CNT_LAST);
        end
        clr_d = (state_d[1] == PRESSED) || (state_d[1] == CHK_REL);
        if (press_d[1]) begin
            run_d = 1'b0;
        end else if (press_d[0]) begin
            run_d = ~run_q;
        end else begin
            run_d = run_q;
        end
    end

    assign RUN       = run_q;
    assign PRESS_A   = press_q[0];
    assign CLR       = clr_q;
    assign CLR_PULSE = press_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner (DB_CYCLES=4).
// Expected press events (button, edge number, RUN after the edge) are queued as
// stimulus is driven; a monitor queues observed pulses; each test drains both.
module tb_button_conditioner;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic A   = 1'b0;
    logic B   = 1'b0;
    logic RUN;
    logic PRESS_A;
    logic CLR;
    logic CLR_PULSE;

    typedef struct packed {
        logic kind;   // 0 = PRESS_A, 1 = CLR_PULSE
        int   edge_n;
        logic run;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    button_conditioner #(
        .DB_CYCLES(4),
        .CNT_BITS (3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .A        (A),
        .B        (B),
        .RUN      (RUN),
        .PRESS_A  (PRESS_A),
        .CLR      (CLR),
        .CLR_PULSE(CLR_PULSE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (PRESS_A === 1'b1)   obs_q.push_back('{kind: 1'b0, edge_n: cyc, run: RUN});
        if (CLR_PULSE === 1'b1) obs_q.push_back('{kind: 1'b1, edge_n: cyc, run: RUN});
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic test_reset;
        ev_t e, o;
        #1 RST = 1'b1;
        step(3);
        checks++;
        if ({RUN, PRESS_A, CLR, CLR_PULSE} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got %b expected 0000", {RUN, PRESS_A, CLR, CLR_PULSE});
        end
        RST = 1'b0;
        step(4);
        checks++;
        if ({RUN, PRESS_A, CLR, CLR_PULSE} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle got %b expected 0000", {RUN, PRESS_A, CLR, CLR_PULSE});
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_events got %0d expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_clean_press;
        ev_t e, o;
        int  e0;
        e0 = cyc + 1;
        A  = 1'b1;
        exp_q.push_back('{kind: 1'b0, edge_n: e0 + 6, run: 1'b1});
        step(5);
        checks++;
        if (RUN !== 1'b0) begin
            failures++;
            $display("FAIL clean_run_early got %b expected 0", RUN);
        end
        step(15);
        checks++;
        if (RUN !== 1'b1) begin
            failures++;
            $display("FAIL clean_run_hold got %b expected 1", RUN);
        end
        A = 1'b0;
        step(10);
        e0 = cyc + 1;
        A  = 1'b1;
        exp_q.push_back('{kind: 1'b0, edge_n: e0 + 6, run: 1'b0});
        step(10);
        A = 1'b0;
        step(10);
        checks++;
        if (RUN !== 1'b0) begin
            failures++;
            $display("FAIL clean_run_second got %b expected 0", RUN);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL clean_event got none expected kind=%0d edge=%0d run=%b", e.kind, e.edge_n, e.run);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL clean_event got kind=%0d edge=%0d run=%b expected kind=%0d edge=%0d run=%b",
                             o.kind, o.edge_n, o.run, e.kind, e.edge_n, e.run);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL clean_extra got %0d extra events expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch;
        ev_t e, o;
        int  e0;
        A = 1'b1;
        step(3);
        A = 1'b0;
        step(10);
        checks++;
        if (RUN !== 1'b0) begin
            failures++;
            $display("FAIL glitch_run got %b expected 0", RUN);
        end
        // A full-latency press right afterwards shows the FSM restarted from IDLE.
        e0 = cyc + 1;
        A  = 1'b1;
        exp_q.push_back('{kind: 1'b0, edge_n: e0 + 6, run: 1'b1});
        step(12);
        A = 1'b0;
        step(10);
        checks++;
        if (RUN !== 1'b1) begin
            failures++;
            $display("FAIL glitch_followup_run got %b expected 1", RUN);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL glitch_event got none expected kind=%0d edge=%0d run=%b", e.kind, e.edge_n, e.run);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL glitch_event got kind=%0d edge=%0d run=%b expected kind=%0d edge=%0d run=%b",
                             o.kind, o.edge_n, o.run, e.kind, e.edge_n, e.run);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_extra got %0d extra events expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_bouncy;
        ev_t  e, o;
        int   c;
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        c   = cyc;
        // Last bounce sample (1) lands on edge c+5 and stays stable from there.
        exp_q.push_back('{kind: 1'b0, edge_n: c + 11, run: 1'b0});
        for (int i = 0; i < 5; i++) begin
            A = pat[i];
            step(1);
        end
        step(10);
        checks++;
        if (CLR !== 1'b0) begin
            failures++;
            $display("FAIL bouncy_clr_hold got %b expected 0", CLR);
        end
        for (int i = 0; i < 5; i++) begin
            A = ~pat[i];
            step(1);
        end
        step(10);
        checks++;
        if ({RUN, CLR} !== 2'b00) begin
            failures++;
            $display("FAIL bouncy_run_clr got %b expected 00", {RUN, CLR});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL bouncy_event got none expected kind=%0d edge=%0d run=%b", e.kind, e.edge_n, e.run);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL bouncy_event got kind=%0d edge=%0d run=%b expected kind=%0d edge=%0d run=%b",
                             o.kind, o.edge_n, o.run, e.kind, e.edge_n, e.run);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL bouncy_extra got %0d extra events expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_clear_while_running;
        ev_t e, o;
        int  e0;
        e0 = cyc + 1;
        A  = 1'b1;
        exp_q.push_back('{kind: 1'b0, edge_n: e0 + 6, run: 1'b1});
        step(10);
        A = 1'b0;
        step(10);
        e0 = cyc + 1;
        B  = 1'b1;
        exp_q.push_back('{kind: 1'b1, edge_n: e0 + 6, run: 1'b0});
        step(6);
        checks++;
        if ({RUN, CLR} !== 2'b10) begin
            failures++;
            $display("FAIL clear_before got run,clr=%b expected 10", {RUN, CLR});
        end
        step(1);
        checks++;
        if ({RUN, CLR, CLR_PULSE} !== 3'b011) begin
            failures++;
            $display("FAIL clear_accept got run,clr,pulse=%b expected 011", {RUN, CLR, CLR_PULSE});
        end
        step(1);
        checks++;
        if (CLR_PULSE !== 1'b0) begin
            failures++;
            $display("FAIL clear_pulse_width got %b expected 0", CLR_PULSE);
        end
        step(10);
        checks++;
        if (CLR !== 1'b1) begin
            failures++;
            $display("FAIL clear_hold got %b expected 1", CLR);
        end
        B = 1'b0;
        step(6);
        checks++;
        if (CLR !== 1'b1) begin
            failures++;
            $display("FAIL clear_release_early got %b expected 1", CLR);
        end
        step(1);
        checks++;
        if (CLR !== 1'b0) begin
            failures++;
            $display("FAIL clear_release got %b expected 0", CLR);
        end
        step(5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL clear_event got none expected kind=%0d edge=%0d run=%b", e.kind, e.edge_n, e.run);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL clear_event got kind=%0d edge=%0d run=%b expected kind=%0d edge=%0d run=%b",
                             o.kind, o.edge_n, o.run, e.kind, e.edge_n, e.run);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL clear_extra got %0d extra events expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_simultaneous;
        ev_t e, o;
        int  e0;
        e0 = cyc + 1;
        A  = 1'b1;
        B  = 1'b1;
        exp_q.push_back('{kind: 1'b0, edge_n: e0 + 6, run: 1'b0});
        exp_q.push_back('{kind: 1'b1, edge_n: e0 + 6, run: 1'b0});
        step(7);
        checks++;
        if ({PRESS_A, CLR_PULSE, RUN} !== 3'b110) begin
            failures++;
            $display("FAIL simul_pulses got pa,cp,run=%b expected 110", {PRESS_A, CLR_PULSE, RUN});
        end
        step(8);
        A = 1'b0;
        B = 1'b0;
        step(10);
        checks++;
        if ({RUN, CLR} !== 2'b00) begin
            failures++;
            $display("FAIL simul_after got run,clr=%b expected 00", {RUN, CLR});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL simul_event got none expected kind=%0d edge=%0d run=%b", e.kind, e.edge_n, e.run);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL simul_event got kind=%0d edge=%0d run=%b expected kind=%0d edge=%0d run=%b",
                             o.kind, o.edge_n, o.run, e.kind, e.edge_n, e.run);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL simul_extra got %0d extra events expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_async_reset;
        ev_t e, o;
        int  e0;
        e0 = cyc + 1;
        A  = 1'b1;
        exp_q.push_back('{kind: 1'b0, edge_n: e0 + 6, run: 1'b1});
        step(10);
        A = 1'b0;
        step(10);
        // A FSM reaches CHK_PRESS with cnt=2 after edge e0+4.
        A = 1'b1;
        step(5);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({RUN, PRESS_A, CLR, CLR_PULSE} !== 4'b0000) begin
            failures++;
            $display("FAIL arst_immediate got %b expected 0000", {RUN, PRESS_A, CLR, CLR_PULSE});
        end
        A = 1'b0;
        step(2);
        RST = 1'b0;
        step(12);
        checks++;
        if (RUN !== 1'b0) begin
            failures++;
            $display("FAIL arst_low_run got %b expected 0", RUN);
        end
        // Second pass: A still high when reset is released.
        A = 1'b1;
        step(5);
        #2 RST = 1'b1;
        step(2);
        RST = 1'b0;
        e0  = cyc + 1;
        exp_q.push_back('{kind: 1'b0, edge_n: e0 + 6, run: 1'b1});
        step(6);
        checks++;
        if ({PRESS_A, RUN} !== 2'b00) begin
            failures++;
            $display("FAIL arst_high_early got pa,run=%b expected 00", {PRESS_A, RUN});
        end
        step(1);
        checks++;
        if ({PRESS_A, RUN} !== 2'b11) begin
            failures++;
            $display("FAIL arst_high_accept got pa,run=%b expected 11", {PRESS_A, RUN});
        end
        step(8);
        A = 1'b0;
        step(10);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL arst_event got none expected kind=%0d edge=%0d run=%b", e.kind, e.edge_n, e.run);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL arst_event got kind=%0d edge=%0d run=%b expected kind=%0d edge=%0d run=%b",
                             o.kind, o.edge_n, o.run, e.kind, e.edge_n, e.run);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL arst_extra got %0d extra events expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bouncy();
        test_clear_while_running();
        test_simultaneous();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
